wb_arbiter: RTL

- Shares the single register-file write port (rd, rd_in, rd_we) among NREQ writeback requesters: ALU, load unit, CSR/mul-div.
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered output stage drives the register file.
- Sits between the execute/memory writeback sources and the `register` instance inside `soc`.

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_arbiter_rr_pick.sv | 36 +++
 rtl/wb_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: data/index widths, requester ids
// and the round-robin pointer advance helper.
package wb_arbiter_pkg;

  localparam int XLEN_DEF = 64;
  localparam int REGW_DEF = 5;
  localparam int IDXW     = 3;

  typedef enum logic [IDXW-1:0] {
    WB_ALU = 3'd0,
    WB_LSU = 3'd1,
    WB_CSR = 3'd2
  } wb_src_e;

  // Pointer moves to the slot just after the winner, wrapping at n.
  function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// otherwise the first set request below ptr_i.
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  // Two constant-indexed passes keep the wrap search free of dynamic selects.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (IDXW'(i) >= ptr_i)) begin
        grant_o[i] = 1'b1;
        idx_o      = IDXW'(i);
        any_o      = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (IDXW'(i) < ptr_i)) begin
        grant_o[i] = 1'b1;
        idx_o      = IDXW'(i);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ
// writeback sources, with one registered output stage.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*REGW-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 hold,
  output logic [REGW-1:0]      rf_rd,
  output logic [XLEN-1:0]      rf_data,
  output logic                 rf_we,
  output logic [2:0]           grant_idx
);

  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [REGW-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic [2:0]      grant_idx_q, grant_idx_d;

  logic [NREQ-1:0] pick_grant;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            xfer;
  logic [REGW-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;

  rr_pick #(.N(NREQ)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign req_ready = (rst || hold) ? '0 : pick_grant;
  assign xfer      = pick_any && !hold && !rst;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_rd   = req_rd[i*REGW +: REGW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 requests are consumed and advance the pointer, but never pulse rf_we.
  always_comb begin
    ptr_d       = ptr_q;
    rf_we_d     = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_data_d   = rf_data_q;
    grant_idx_d = grant_idx_q;
    if (xfer) begin
      ptr_d = rr_next(pick_idx, NREQ);
      if (sel_rd != '0) begin
        rf_we_d     = 1'b1;
        rf_rd_d     = sel_rd;
        rf_data_d   = sel_data;
        grant_idx_d = pick_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_data_q   <= '0;
      grant_idx_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_data_q   <= rf_data_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_data   = rf_data_q;
  assign grant_idx = grant_idx_q;

endmodule
